// File: rtl/pmp_region_encoder.sv
// Turns one region request into the PMP CSR write sequence (OFF, address(es), cfg); TOR mode only with PMP_TOR_EN.
// Latency: reject responds 2 cycles after accept; NAPOT/NA4 responds after 3 writes, TOR after 4.
// Backpressure: each CSR write holds its fields until CSRWriteAck; no new request until the response pulse ends.
module pmp_region_encoder #(
    parameter int PA_BITS     = 56,
    parameter int XLEN        = 64,
    parameter int PMP_ENTRIES = 16,
    localparam int IDXW       = $clog2(PMP_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic [PA_BITS-1:0]     ReqBase,
    input  logic [5:0]             ReqLog2Size,
    input  logic [3:0]             ReqPerm,
    input  logic [IDXW-1:0]        ReqIndex,
    input  logic                   ReqTOR,
    input  logic [PMP_ENTRIES-1:0] LockedVec,
    output logic                   CSRWriteValid,
    output logic                   CSRWriteIsCfg,
    output logic [IDXW-1:0]        CSRWriteIndex,
    output logic [XLEN-1:0]        CSRWriteData,
    input  logic                   CSRWriteAck,
    output logic                   RespValid,
    output logic                   RespError
);

    typedef logic [PA_BITS:0] wide_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIS,
`ifdef PMP_TOR_EN
        ADR_LO,
`endif
        ADR,
        CFG,
        RESP
    } state_t;

    state_t            state;
    logic [PA_BITS-1:0] base_q;
    logic [5:0]        k_q;
    logic [3:0]        perm_q;
    logic [IDXW-1:0]   idx_q;
    logic              tor_q;

    wide_t             base_w;
    wide_t             size_w;
    wide_t             napot_mask;
    wide_t             adr_w;
    logic              chk_err;
    logic [1:0]        a_field;
    logic [XLEN-1:0]   adr_dat;
    logic [XLEN-1:0]   cfg_dat;

    // One extra bit so base + size can reach exactly 2^PA_BITS without wrapping.
    assign base_w     = {1'b0, base_q};
    assign size_w     = wide_t'(1) << k_q;
    assign napot_mask = (size_w >> 3) - wide_t'(1);

`ifdef PMP_TOR_EN
    wide_t             end_w;
    logic [IDXW-1:0]   idx_prev;
    logic [XLEN-1:0]   lo_dat;

    assign end_w    = base_w + size_w;
    assign idx_prev = idx_q - IDXW'(1);
    assign lo_dat   = XLEN'(base_w >> 2);
`endif

    always_comb begin
        chk_err = 1'b0;
        if (k_q < 6'd2)                                    chk_err = 1'b1;
        if (int'(k_q) > PA_BITS)                           chk_err = 1'b1;
        if (base_q[1:0] != 2'b00)                          chk_err = 1'b1;
        if (!tor_q && ((base_w & (size_w - wide_t'(1))) != '0)) chk_err = 1'b1;
        if (LockedVec[idx_q])                              chk_err = 1'b1;
`ifdef PMP_TOR_EN
        if (tor_q && (idx_q == '0))                        chk_err = 1'b1;
        if (tor_q && LockedVec[idx_prev])                  chk_err = 1'b1;
        if (tor_q && end_w[PA_BITS] && (end_w[PA_BITS-1:0] != '0)) chk_err = 1'b1;
`else
        if (tor_q)                                         chk_err = 1'b1;
`endif
    end

    always_comb begin
        adr_w = (base_w >> 2) | napot_mask;
        if (k_q == 6'd2) adr_w = base_w >> 2;
`ifdef PMP_TOR_EN
        if (tor_q) adr_w = end_w >> 2;
`endif
    end

    assign a_field = tor_q ? 2'b01 : ((k_q == 6'd2) ? 2'b10 : 2'b11);
    assign adr_dat = XLEN'(adr_w);
    assign cfg_dat = XLEN'({perm_q[3], 2'b00, a_field, perm_q[2:0]});

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ReqReady      <= 1'b1;
            CSRWriteValid <= 1'b0;
            CSRWriteIsCfg <= 1'b0;
            CSRWriteIndex <= '0;
            CSRWriteData  <= '0;
            RespValid     <= 1'b0;
            RespError     <= 1'b0;
            base_q        <= '0;
            k_q           <= '0;
            perm_q        <= '0;
            idx_q         <= '0;
            tor_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        base_q   <= ReqBase;
                        k_q      <= ReqLog2Size;
                        perm_q   <= ReqPerm;
                        idx_q    <= ReqIndex;
                        tor_q    <= ReqTOR;
                        ReqReady <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk_err) begin
                        RespValid <= 1'b1;
                        RespError <= 1'b1;
                        state     <= RESP;
                    end else begin
                        // Entry goes OFF first so no half-updated region is ever live.
                        CSRWriteValid <= 1'b1;
                        CSRWriteIsCfg <= 1'b1;
                        CSRWriteIndex <= idx_q;
                        CSRWriteData  <= '0;
                        state         <= DIS;
                    end
                end
                DIS: begin
                    if (CSRWriteAck) begin
`ifdef PMP_TOR_EN
                        if (tor_q) begin
                            CSRWriteIsCfg <= 1'b0;
                            CSRWriteIndex <= idx_prev;
                            CSRWriteData  <= lo_dat;
                            state         <= ADR_LO;
                        end else
`endif
                        begin
                            CSRWriteIsCfg <= 1'b0;
                            CSRWriteIndex <= idx_q;
                            CSRWriteData  <= adr_dat;
                            state         <= ADR;
                        end
                    end
                end
`ifdef PMP_TOR_EN
                ADR_LO: begin
                    if (CSRWriteAck) begin
                        CSRWriteIndex <= idx_q;
                        CSRWriteData  <= adr_dat;
                        state         <= ADR;
                    end
                end
`endif
                ADR: begin
                    if (CSRWriteAck) begin
                        CSRWriteIsCfg <= 1'b1;
                        CSRWriteData  <= cfg_dat;
                        state         <= CFG;
                    end
                end
                CFG: begin
                    if (CSRWriteAck) begin
                        CSRWriteValid <= 1'b0;
                        CSRWriteIsCfg <= 1'b0;
                        CSRWriteIndex <= '0;
                        CSRWriteData  <= '0;
                        RespValid     <= 1'b1;
                        RespError     <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    RespValid <= 1'b0;
                    RespError <= 1'b0;
                    ReqReady  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    ReqReady <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_region_encoder.sv
// Directed bench for pmp_region_encoder: encodings, rejects, backpressure and reset abort.
module tb_pmp_region_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [55:0] ReqBase;
    logic [5:0]  ReqLog2Size;
    logic [3:0]  ReqPerm;
    logic [3:0]  ReqIndex;
    logic        ReqTOR;
    logic [15:0] LockedVec;
    logic        CSRWriteValid;
    logic        CSRWriteIsCfg;
    logic [3:0]  CSRWriteIndex;
    logic [63:0] CSRWriteData;
    logic        CSRWriteAck;
    logic        RespValid;
    logic        RespError;

    pmp_region_encoder dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqBase(ReqBase),
        .ReqLog2Size(ReqLog2Size), .ReqPerm(ReqPerm), .ReqIndex(ReqIndex),
        .ReqTOR(ReqTOR), .LockedVec(LockedVec),
        .CSRWriteValid(CSRWriteValid), .CSRWriteIsCfg(CSRWriteIsCfg),
        .CSRWriteIndex(CSRWriteIndex), .CSRWriteData(CSRWriteData),
        .CSRWriteAck(CSRWriteAck), .RespValid(RespValid), .RespError(RespError)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations of the last request, indexed by write order.
    logic        w_iscfg [16];
    logic [3:0]  w_idx   [16];
    logic [63:0] w_dat   [16];
    int          w_cyc   [16];
    int          nw, vld_seen, resp_cnt, resp_cyc, stab_err;
    logic        resp_err, rdy_after;

    typedef struct {
        logic [55:0] base;
        logic [5:0]  k;
        logic [3:0]  perm;
        logic [3:0]  idx;
        logic        tor;
        logic [15:0] locked;
    } req_t;

    typedef struct {
        logic [55:0] base;
        logic [5:0]  k;
        logic [3:0]  perm;
        logic [3:0]  idx;
        logic [63:0] addr;
        logic [7:0]  cfg;
    } enc_t;

    // Issues one request from a negedge; cycle 1 is the first cycle after the accept edge.
    task automatic run_req(input req_t r, input bit bp);
        int   wait_cnt;
        logic [68:0] saved;
        nw = 0; vld_seen = 0; resp_cnt = 0; resp_cyc = -1; stab_err = 0;
        resp_err = 1'b0; rdy_after = 1'b0; wait_cnt = 0; saved = '0;
        ReqBase = r.base; ReqLog2Size = r.k; ReqPerm = r.perm; ReqIndex = r.idx;
        ReqTOR = r.tor; LockedVec = r.locked; ReqValid = 1'b1; CSRWriteAck = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) ReqValid = 1'b0;
            if (CSRWriteValid) begin
                vld_seen++;
                if (wait_cnt > 0 && {CSRWriteIsCfg, CSRWriteIndex, CSRWriteData} != saved)
                    stab_err++;
                if (bp && wait_cnt < 3) begin
                    if (wait_cnt == 0) saved = {CSRWriteIsCfg, CSRWriteIndex, CSRWriteData};
                    CSRWriteAck = 1'b0;
                    wait_cnt++;
                end else begin
                    CSRWriteAck = 1'b1;
                    if (nw < 16) begin
                        w_iscfg[nw] = CSRWriteIsCfg; w_idx[nw] = CSRWriteIndex;
                        w_dat[nw] = CSRWriteData; w_cyc[nw] = c;
                    end
                    nw++;
                    wait_cnt = 0;
                end
            end else begin
                CSRWriteAck = 1'b0;
            end
            if (RespValid) begin
                resp_cnt++;
                if (resp_cyc < 0) begin resp_cyc = c; resp_err = RespError; end
            end
            if (resp_cyc >= 0 && c == resp_cyc + 1) rdy_after = ReqReady;
            if (resp_cyc >= 0 && c >= resp_cyc + 3) break;
        end
        CSRWriteAck = 1'b0;
        LockedVec = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ReqReady, CSRWriteValid, RespValid, RespError, CSRWriteIsCfg} !== 5'b10000)
            begin errors++; $display("FAIL reset_ctrl got %b want 10000",
                {ReqReady, CSRWriteValid, RespValid, RespError, CSRWriteIsCfg}); end
        checks++;
        if (CSRWriteIndex !== 4'd0 || CSRWriteData !== 64'd0)
            begin errors++; $display("FAIL reset_fields got idx %h data %h want 0 0",
                CSRWriteIndex, CSRWriteData); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encode();
        enc_t v[4];
        logic [68:0] exp_w[3];
        v[0] = '{56'h8000_0000, 6'd12, 4'b0111, 4'd3, 64'h2000_01FF, 8'h1F};
        v[1] = '{56'h1000,      6'd2,  4'b0001, 4'd0, 64'h400,       8'h11};
        v[2] = '{56'h20,        6'd3,  4'b0011, 4'd2, 64'h8,         8'h1B};
        v[3] = '{56'h0,         6'd56, 4'b1100, 4'd7, 64'h001F_FFFF_FFFF_FFFF, 8'h9C};
        for (int t = 0; t < 4; t++) begin
            run_req('{v[t].base, v[t].k, v[t].perm, v[t].idx, 1'b0, 16'h0}, 1'b0);
            exp_w[0] = {1'b1, v[t].idx, 64'h0};
            exp_w[1] = {1'b0, v[t].idx, v[t].addr};
            exp_w[2] = {1'b1, v[t].idx, 56'h0, v[t].cfg};
            checks++;
            if (nw !== 3) begin errors++; $display("FAIL enc%0d_nwrites got %0d want 3", t, nw); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (nw <= i || {w_iscfg[i], w_idx[i], w_dat[i]} !== exp_w[i] || w_cyc[i] != i + 2)
                    begin errors++; $display("FAIL enc%0d_write%0d got %h@%0d want %h@%0d",
                        t, i, {w_iscfg[i], w_idx[i], w_dat[i]}, w_cyc[i], exp_w[i], i + 2); end
            end
            checks++;
            if (resp_cyc != 5 || resp_err !== 1'b0 || resp_cnt != 1 || rdy_after !== 1'b1)
                begin errors++; $display("FAIL enc%0d_resp got cyc %0d err %b cnt %0d rdy %b want 5 0 1 1",
                    t, resp_cyc, resp_err, resp_cnt, rdy_after); end
        end
    endtask

    task automatic test_tor();
`ifdef PMP_TOR_EN
        logic [68:0] exp_w[4];
        run_req('{56'h1000, 6'd16, 4'b1011, 4'd5, 1'b1, 16'h0}, 1'b0);
        exp_w[0] = {1'b1, 4'd5, 64'h0};
        exp_w[1] = {1'b0, 4'd4, 64'h400};
        exp_w[2] = {1'b0, 4'd5, 64'h4400};
        exp_w[3] = {1'b1, 4'd5, 64'h8B};
        checks++;
        if (nw !== 4) begin errors++; $display("FAIL tor_nwrites got %0d want 4", nw); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (nw <= i || {w_iscfg[i], w_idx[i], w_dat[i]} !== exp_w[i] || w_cyc[i] != i + 2)
                begin errors++; $display("FAIL tor_write%0d got %h@%0d want %h@%0d",
                    i, {w_iscfg[i], w_idx[i], w_dat[i]}, w_cyc[i], exp_w[i], i + 2); end
        end
        checks++;
        if (resp_cyc != 6 || resp_err !== 1'b0 || resp_cnt != 1 || rdy_after !== 1'b1)
            begin errors++; $display("FAIL tor_resp got cyc %0d err %b cnt %0d rdy %b want 6 0 1 1",
                resp_cyc, resp_err, resp_cnt, rdy_after); end
        // Region ending exactly at the top of the address space is legal.
        run_req('{56'hFF_FFFF_FFFF_F000, 6'd12, 4'b0001, 4'd9, 1'b1, 16'h0}, 1'b0);
        checks++;
        if (nw != 4 || w_dat[2] !== 64'h0040_0000_0000_0000 || w_dat[1] !== 64'h003F_FFFF_FFFF_FC00 || resp_err !== 1'b0)
            begin errors++; $display("FAIL tor_top got n %0d lo %h hi %h err %b want 4 003ffffffffffc00 0040000000000000 0",
                nw, w_dat[1], w_dat[2], resp_err); end
`else
        run_req('{56'h1000, 6'd16, 4'b1011, 4'd5, 1'b1, 16'h0}, 1'b0);
        checks++;
        if (vld_seen != 0 || resp_cyc != 2 || resp_err !== 1'b1 || resp_cnt != 1)
            begin errors++; $display("FAIL tor_disabled got vld %0d cyc %0d err %b cnt %0d want 0 2 1 1",
                vld_seen, resp_cyc, resp_err, resp_cnt); end
`endif
    endtask

    task automatic test_errors();
        req_t e[8];
        int   n;
        e[0] = '{56'h1010,      6'd6,  4'b0111, 4'd1, 1'b0, 16'h0};
        e[1] = '{56'h8000_0000, 6'd12, 4'b0111, 4'd3, 1'b0, 16'h0008};
        e[2] = '{56'h1000,      6'd16, 4'b1011, 4'd0, 1'b1, 16'h0};
        e[3] = '{56'h1000,      6'd1,  4'b0001, 4'd2, 1'b0, 16'h0};
        e[4] = '{56'h0,         6'd57, 4'b0001, 4'd2, 1'b0, 16'h0};
        e[5] = '{56'h1002,      6'd2,  4'b0001, 4'd2, 1'b0, 16'h0};
        n = 6;
`ifdef PMP_TOR_EN
        e[6] = '{56'h1000,              6'd16, 4'b1011, 4'd5, 1'b1, 16'h0010};
        e[7] = '{56'hFF_FFFF_FFFF_F000, 6'd13, 4'b0001, 4'd9, 1'b1, 16'h0};
        n = 8;
`endif
        for (int t = 0; t < n; t++) begin
            run_req(e[t], 1'b0);
            checks++;
            if (vld_seen != 0 || resp_cyc != 2 || resp_err !== 1'b1 || resp_cnt != 1 || rdy_after !== 1'b1)
                begin errors++; $display("FAIL err%0d got vld %0d cyc %0d err %b cnt %0d rdy %b want 0 2 1 1 1",
                    t, vld_seen, resp_cyc, resp_err, resp_cnt, rdy_after); end
        end
    endtask

    task automatic test_backpressure();
        logic [68:0] exp_w[3];
        run_req('{56'h8000_0000, 6'd12, 4'b0111, 4'd3, 1'b0, 16'h0}, 1'b1);
        exp_w[0] = {1'b1, 4'd3, 64'h0};
        exp_w[1] = {1'b0, 4'd3, 64'h2000_01FF};
        exp_w[2] = {1'b1, 4'd3, 64'h1F};
        checks++;
        if (nw != 3 || stab_err != 0 || vld_seen != 12)
            begin errors++; $display("FAIL bp_writes got n %0d unstable %0d vldcyc %0d want 3 0 12",
                nw, stab_err, vld_seen); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (nw <= i || {w_iscfg[i], w_idx[i], w_dat[i]} !== exp_w[i])
                begin errors++; $display("FAIL bp_write%0d got %h want %h",
                    i, {w_iscfg[i], w_idx[i], w_dat[i]}, exp_w[i]); end
        end
        checks++;
        if (resp_cnt != 1 || resp_err !== 1'b0 || rdy_after !== 1'b1)
            begin errors++; $display("FAIL bp_resp got cnt %0d err %b rdy %b want 1 0 1",
                resp_cnt, resp_err, rdy_after); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int bad = 0;
        ReqBase = 56'h8000_0000; ReqLog2Size = 6'd12; ReqPerm = 4'b0111; ReqIndex = 4'd3;
        ReqTOR = 1'b0; LockedVec = '0; ReqValid = 1'b1; CSRWriteAck = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            ReqValid = 1'b0;
            if (CSRWriteValid && !CSRWriteIsCfg) begin
                CSRWriteAck = 1'b0; found = 1; break;
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!found || CSRWriteValid !== 1'b1 || CSRWriteData !== 64'h2000_01FF)
            begin errors++; $display("FAIL rmid_adr_wait got found %0d vld %b data %h want 1 1 20001ff",
                found, CSRWriteValid, CSRWriteData); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ReqReady, CSRWriteValid, RespValid, RespError} !== 4'b1000)
            begin errors++; $display("FAIL rmid_after_reset got %b want 1000",
                {ReqReady, CSRWriteValid, RespValid, RespError}); end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (RespValid || CSRWriteValid) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rmid_quiet got %0d active cycles want 0", bad); end
    endtask

    initial begin
        reset = 1'b1; ReqValid = 1'b0; ReqBase = '0; ReqLog2Size = '0; ReqPerm = '0;
        ReqIndex = '0; ReqTOR = 1'b0; LockedVec = '0; CSRWriteAck = 1'b0;
        test_reset();
        test_encode();
        test_tor();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/pmp_region_encoder.md
PMP_REGION_ENCODER -- requirements
Module: pmp_region_encoder

Interface
REQ-001 SHALL provide parameter PA_BITS, default 56, physical address width.
REQ-002 SHALL provide parameter XLEN, default 64, CSR data width.
REQ-003 SHALL provide parameter PMP_ENTRIES, default 16, number of PMP entries; IDXW = log2(PMP_ENTRIES).
REQ-004 SHALL provide ports:
 clk  in  1  clock; one clock domain.
 reset  in  1  synchronous, active-high reset.
 ReqValid  in  1  region request valid.
 ReqReady  out  1  request accept.
 ReqBase  in  PA_BITS  region base byte address.
 ReqLog2Size  in  6  region size k; size = 2^k bytes.
 ReqPerm  in  4  {L,X,W,R}.
 ReqIndex  in  IDXW  target PMP entry.
 ReqTOR  in  1  encode as TOR instead of NA4/NAPOT.
 LockedVec  in  PMP_ENTRIES  current L bit per entry.
 CSRWriteValid  out  1  PMP CSR write request.
 CSRWriteIsCfg  out  1  1 = pmpcfg byte, 0 = pmpaddr.
 CSRWriteIndex  out  IDXW  entry written.
 CSRWriteData  out  XLEN  pmpaddr value, or cfg byte in [7:0] with upper bits zero.
 CSRWriteAck  in  1  write accepted.
 RespValid  out  1  one-cycle completion pulse.
 RespError  out  1  request rejected; valid with RespValid.

Function
REQ-005 SHALL set ReqReady=1 only in IDLE; accept on ReqValid&ReqReady; capture all Req* fields into registers.
REQ-006 SHALL implement FSM IDLE->CHECK->DIS->[ADR_LO]->ADR->CFG->RESP->IDLE; ADR_LO only when ReqTOR=1.
REQ-007 CHECK SHALL set error and go to RESP if: k<2; k>PA_BITS; ReqBase[1:0]!=0; non-TOR and ReqBase[k-1:0]!=0; LockedVec[idx]=1; TOR and idx=0; TOR and LockedVec[idx-1]=1; TOR and ReqBase+2^k > 2^PA_BITS.
REQ-008 DIS SHALL write cfg[idx]=0x00 (entry OFF before its address changes).
REQ-009 ADR_LO SHALL write addr[idx-1]=ReqBase>>2.
REQ-010 ADR SHALL write addr[idx]: TOR (ReqBase+2^k)>>2; k=2 ReqBase>>2; k>=3 (ReqBase>>2)|(2^(k-3)-1); zero-extended to XLEN.
REQ-011 CFG SHALL write cfg[idx]={L,2'b00,A,X,W,R} with A=01 TOR, 10 k=2, 11 otherwise.
REQ-012 In each write state, CSRWriteValid=1 with all CSRWrite* fields stable until CSRWriteAck; advance on the ack cycle; CSRWriteValid may stay high into the next write state with new fields.
REQ-013 RESP SHALL pulse RespValid for exactly one cycle with RespError; no CSR writes after an error.
REQ-014 Latency, ack tied high, accept at cycle 0: error RespValid cycle 2; NAPOT/NA4 writes cycles 2,3,4, RespValid 5; TOR writes 2-5, RespValid 6; ReqReady high the cycle after RespValid.
REQ-015 LockedVec SHALL be sampled only in CHECK.
REQ-016 Address arithmetic SHALL be PA_BITS+1 wide so the top-overflow check is exact.

Reset
REQ-017 reset SHALL force IDLE; ReqReady=1, CSRWriteValid=0, RespValid=0, RespError=0, other outputs 0, on the cycle after reset asserts.
REQ-018 Reset mid-operation SHALL abort without response; completed writes not undone (entry left OFF if DIS completed).

Configuration
REQ-019 With PMP_TOR_EN defined, TOR is supported as above.
REQ-020 Without PMP_TOR_EN, ADR_LO and TOR arithmetic SHALL be absent and ReqTOR=1 SHALL return RespError=1 with no writes.

Verification
REQ-021 NAPOT: base 0x8000_0000, k=12, idx 3, perm 0111 -> cfg[3]=0x00, addr[3]=0x2000_01FF, cfg[3]=0x1F, RespError=0.
REQ-022 NA4: base 0x1000, k=2, idx 0, perm 0001 -> cfg[0]=0x00, addr[0]=0x400, cfg[0]=0x11.
REQ-023 TOR (PMP_TOR_EN): base 0x1000, k=16, idx 5, perm 1011 -> cfg[5]=0x00, addr[4]=0x400, addr[5]=0x4400, cfg[5]=0x8B; without macro -> RespError=1, no writes.
REQ-024 Errors: base 0x1010 k=6; LockedVec[3]=1 idx 3; TOR idx 0 -> each RespValid cycle 2, RespError=1, CSRWriteValid never asserted.
REQ-025 Backpressure: hold CSRWriteAck low 3 cycles per write -> fields stable while waiting, order unchanged, RespValid once.
REQ-026 Reset asserted during ADR wait -> next cycle IDLE, CSRWriteValid=0, no RespValid.
